// File: rtl/alu_issue_if.sv
// Issue-side bundle for alu_issue_unit: instruction fields in, ALU drive/return, captured result out.
// The issue side uses valid/ready: a transfer happens on a rising edge where valid && ready; ready never looks at valid.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_acl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_taken;
    logic        out_illegal;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm,
               alu_result, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_acl,
               out_valid, out_result, out_zero, out_taken, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm,
               alu_result, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_acl,
               out_valid, out_result, out_zero, out_taken, out_illegal
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Two-stage ALU issue/capture: S1 encodes RV32 R/I/branch fields into ALU control and operands,
// S2 registers the external ALU's result, zero flag and branch decision.
module alu_issue_unit (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ACL_ADD = 4'b0000;
    localparam logic [3:0] ACL_SUB = 4'b0001;
    localparam logic [3:0] ACL_SLL = 4'b0010;
    localparam logic [3:0] ACL_SLT = 4'b0011;
    localparam logic [3:0] ACL_XOR = 4'b0100;
    localparam logic [3:0] ACL_SRL = 4'b0101;
    localparam logic [3:0] ACL_OR  = 4'b0110;
    localparam logic [3:0] ACL_AND = 4'b0111;

    logic        is_r, is_i, is_br, is_shift;
    logic [31:0] op_b;
    logic        dec_illegal, dec_branch;
    logic [3:0]  dec_acl;
    logic [31:0] dec_a, dec_b;

    logic        s1_valid, s1_branch, s1_illegal, s1_f3_0;
    logic [31:0] s1_a, s1_b;
    logic [3:0]  s1_acl;

    logic        out_valid_q, out_zero_q, out_taken_q, out_illegal_q;
    logic [31:0] out_result_q;

    logic        advance, accept;

    always_comb begin
        is_r        = (bus.in_opcode == OP_R);
        is_i        = (bus.in_opcode == OP_I);
        is_br       = (bus.in_opcode == OP_BR);
        is_shift    = (bus.in_funct3[1:0] == 2'b01);
        op_b        = is_r ? bus.in_rs2 : bus.in_imm;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        dec_acl     = ACL_ADD;
        dec_a       = bus.in_rs1;
        dec_b       = 32'd0;
        if (is_r || is_i) begin
            case (bus.in_funct3)
                3'b000:  dec_acl = (is_r && bus.in_funct7_5) ? ACL_SUB : ACL_ADD;
                3'b001:  dec_acl = ACL_SLL;
                3'b010:  dec_acl = ACL_SLT;
                3'b011:  dec_illegal = 1'b1;
                3'b100:  dec_acl = ACL_XOR;
                3'b101:  dec_acl = ACL_SRL;
                3'b110:  dec_acl = ACL_OR;
                default: dec_acl = ACL_AND;
            endcase
            // funct7_5 only selects sub for R-type; for I-type it is just an immediate bit
            if (is_r && bus.in_funct7_5 && (bus.in_funct3 != 3'b000))
                dec_illegal = 1'b1;
            if ((bus.in_funct3 == 3'b101) && bus.in_funct7_5)
                dec_illegal = 1'b1;
            if (is_i && is_shift && (bus.in_imm[11:5] != 7'd0))
                dec_illegal = 1'b1;
            dec_b = is_shift ? {27'd0, op_b[4:0]} : op_b;
        end else if (is_br) begin
            dec_branch = 1'b1;
            dec_acl    = ACL_SUB;
            dec_b      = bus.in_rs2;
            if (bus.in_funct3[2:1] != 2'b00)
                dec_illegal = 1'b1;
        end else begin
            dec_illegal = 1'b1;
        end
        if (dec_illegal) begin
            dec_a   = 32'd0;
            dec_b   = 32'd0;
            dec_acl = ACL_ADD;
        end
    end

    // S2 moves whenever it is empty or being drained; S1 may refill in the same cycle.
    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || advance;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= 32'd0;
            s1_b       <= 32'd0;
            s1_acl     <= ACL_ADD;
            s1_branch  <= 1'b0;
            s1_illegal <= 1'b0;
            s1_f3_0    <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_a       <= dec_a;
            s1_b       <= dec_b;
            s1_acl     <= dec_acl;
            s1_branch  <= dec_branch;
            s1_illegal <= dec_illegal;
            s1_f3_0    <= bus.in_funct3[0];
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= 32'd0;
            out_zero_q    <= 1'b0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else if (advance) begin
            out_valid_q   <= s1_valid;
            out_result_q  <= s1_illegal ? 32'd0 : bus.alu_result;
            out_zero_q    <= !s1_illegal && bus.alu_zero;
            out_taken_q   <= s1_branch && !s1_illegal && (s1_f3_0 ? !bus.alu_zero : bus.alu_zero);
            out_illegal_q <= s1_illegal;
        end
    end

    assign bus.alu_a       = s1_a;
    assign bus.alu_b       = s1_b;
    assign bus.alu_acl     = s1_acl;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_zero    = out_zero_q;
    assign bus.out_taken   = out_taken_q;
    assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: table of directed instructions, hand-built stall/reset sequences,
// and a random stream scored against an instruction-level reference model.
module tb_alu_issue_unit;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  acl;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        t;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The ALU itself lives outside the unit; this is its behaviour.
    logic [31:0] alu_r;
    always_comb begin
        case (bus.alu_acl)
            4'd0:    alu_r = bus.alu_a + bus.alu_b;
            4'd1:    alu_r = bus.alu_a - bus.alu_b;
            4'd2:    alu_r = bus.alu_a << bus.alu_b[4:0];
            4'd3:    alu_r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'd4:    alu_r = bus.alu_a ^ bus.alu_b;
            4'd5:    alu_r = bus.alu_a >> bus.alu_b[4:0];
            4'd6:    alu_r = bus.alu_a | bus.alu_b;
            4'd7:    alu_r = bus.alu_a & bus.alu_b;
            default: alu_r = 32'd0;
        endcase
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_zero   = (alu_r == 32'd0);

    int errors = 0;
    int checks = 0;

    logic [34:0] exp_q[$];
    logic        hold_pend = 1'b0;
    logic [35:0] hold_val  = '0;
    logic        acc_flag  = 1'b0;

    logic [6:0]  g_op;
    logic [2:0]  g_f3;
    logic        g_f7;
    logic [31:0] g_rs1, g_rs2, g_imm;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {illegal, taken, zero, result} of one instruction, straight from the ISA rules.
    function automatic logic [34:0] predict(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] imm);
        logic [31:0] y, r;
        logic        ill, tk, z;
        ill = 1'b0;
        tk  = 1'b0;
        r   = 32'd0;
        if (op == OP_R || op == OP_I) begin
            y = (op == OP_R) ? rs2 : imm;
            case (f3)
                3'd0: r = (op == OP_R && f7) ? rs1 - y : rs1 + y;
                3'd1: r = rs1 << y[4:0];
                3'd2: r = ($signed(rs1) < $signed(y)) ? 32'd1 : 32'd0;
                3'd3: ill = 1'b1;
                3'd4: r = rs1 ^ y;
                3'd5: r = rs1 >> y[4:0];
                3'd6: r = rs1 | y;
                default: r = rs1 & y;
            endcase
            if (op == OP_R && f7 && f3 != 3'd0) ill = 1'b1;
            if (f3 == 3'd5 && f7) ill = 1'b1;
            if (op == OP_I && (f3 == 3'd1 || f3 == 3'd5) && imm[11:5] != 7'd0) ill = 1'b1;
        end else if (op == OP_BR) begin
            r = rs1 - rs2;
            if (f3 == 3'd0)      tk = (rs1 == rs2);
            else if (f3 == 3'd1) tk = (rs1 != rs2);
            else                 ill = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            r  = 32'd0;
            tk = 1'b0;
        end
        z = !ill && (r == 32'd0);
        return {ill, tk, z, r};
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        bus.in_valid    = v;
        bus.in_opcode   = op;
        bus.in_funct3   = f3;
        bus.in_funct7_5 = f7;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_imm      = imm;
    endtask

    task automatic rand_op();
        int          k;
        logic [11:0] iv;
        k = $urandom_range(0, 9);
        if (k < 4)      g_op = OP_R;
        else if (k < 7) g_op = OP_I;
        else if (k < 9) g_op = OP_BR;
        else            g_op = 7'($urandom_range(0, 127));
        g_f3  = 3'($urandom_range(0, 7));
        g_rs1 = $urandom;
        g_rs2 = ($urandom_range(0, 3) == 0) ? g_rs1 : $urandom;
        iv    = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 31)) : 12'($urandom_range(0, 4095));
        g_imm = {{20{iv[11]}}, iv};
        g_f7  = (g_op == OP_I) ? g_imm[10] : ($urandom_range(0, 3) == 0);
    endtask

    // One clock of the scoreboarded flow: drive before the edge, score what that edge will transfer.
    task automatic step(input logic v, input logic rdy);
        logic [35:0] cur;
        @(negedge clk);
        drive(v, g_op, g_f3, g_f7, g_rs1, g_rs2, g_imm);
        bus.out_ready = rdy;
        #1;
        cur = {bus.out_valid, bus.out_illegal, bus.out_taken, bus.out_zero, bus.out_result};
        if (hold_pend) chk("stall_hold", cur, hold_val);
        chk("in_ready", bus.in_ready, !(exp_q.size() == 2 && !rdy));
        if (bus.out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: out_valid=1 result=0x%08h with nothing expected at %0t",
                         bus.out_result, $time);
            end else begin
                chk("out_fields", cur[34:0], exp_q.pop_front());
            end
        end
        hold_pend = bus.out_valid && !rdy;
        hold_val  = cur;
        acc_flag  = v && bus.in_ready;
        if (acc_flag) exp_q.push_back(predict(g_op, g_f3, g_f7, g_rs1, g_rs2, g_imm));
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        //          op     f3    f7  rs1           rs2           imm           acl   b             res           z  t  ill
        vecs[0]  = '{OP_R,  3'd0, 1'b0, 32'd5,        32'd7,        32'd0,        4'd0, 32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_R,  3'd0, 1'b1, 32'h1234,     32'h1234,     32'd0,        4'd1, 32'h1234,     32'd0,        1'b1, 1'b0, 1'b0};
        vecs[2]  = '{OP_BR, 3'd0, 1'b0, 32'h1234,     32'h1234,     32'd0,        4'd1, 32'h1234,     32'd0,        1'b1, 1'b1, 1'b0};
        vecs[3]  = '{OP_BR, 3'd1, 1'b0, 32'h1234,     32'h1234,     32'd0,        4'd1, 32'h1234,     32'd0,        1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_I,  3'd1, 1'b0, 32'd1,        32'd0,        32'h004,      4'd2, 32'd4,        32'd16,       1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_R,  3'd1, 1'b0, 32'd1,        32'h23,       32'd0,        4'd2, 32'd3,        32'd8,        1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_I,  3'd5, 1'b1, 32'h80000000, 32'd0,        32'h404,      4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[7]  = '{OP_R,  3'd3, 1'b0, 32'd9,        32'd3,        32'd0,        4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[8]  = '{OP_LD, 3'd2, 1'b0, 32'd9,        32'd3,        32'd8,        4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[9]  = '{OP_BR, 3'd4, 1'b0, 32'd4,        32'd4,        32'd0,        4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[10] = '{OP_R,  3'd2, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'd3, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_I,  3'd5, 1'b0, 32'h80000000, 32'd0,        32'h01F,      4'd5, 32'd31,       32'd1,        1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_I,  3'd6, 1'b1, 32'h0F,       32'd0,        32'hFFFFFFF0, 4'd6, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_R,  3'd4, 1'b0, 32'hA5A5,     32'hA5A5,     32'd0,        4'd4, 32'hA5A5,     32'd0,        1'b1, 1'b0, 1'b0};
        vecs[14] = '{OP_I,  3'd7, 1'b1, 32'hFFF,      32'd0,        32'h400,      4'd7, 32'h400,      32'h400,      1'b0, 1'b0, 1'b0};
        vecs[15] = '{OP_R,  3'd1, 1'b1, 32'd1,        32'd2,        32'd0,        4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[16] = '{OP_I,  3'd1, 1'b0, 32'd1,        32'd0,        32'h024,      4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[17] = '{OP_I,  3'd0, 1'b1, 32'd1,        32'd0,        32'hFFFFFFFF, 4'd0, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};

        // Clock/reset
        drive(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_acl", bus.alu_acl, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_flags", {bus.out_zero, bus.out_taken, bus.out_illegal}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", bus.in_ready, 1);

        // Directed table, one instruction at a time, consumer always ready
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            bus.out_ready = 1'b1;
            #1 chk("tbl_in_ready", bus.in_ready, 1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk($sformatf("tbl%0d_acl", i), bus.alu_acl, vecs[i].acl);
            chk($sformatf("tbl%0d_alu_a", i), bus.alu_a, vecs[i].ill ? 32'd0 : vecs[i].rs1);
            chk($sformatf("tbl%0d_alu_b", i), bus.alu_b, vecs[i].b);
            chk($sformatf("tbl%0d_early_valid", i), bus.out_valid, 0);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, 1);
            chk($sformatf("tbl%0d_result", i), bus.out_result, vecs[i].res);
            chk($sformatf("tbl%0d_zero", i), bus.out_zero, vecs[i].z);
            chk($sformatf("tbl%0d_taken", i), bus.out_taken, vecs[i].t);
            chk($sformatf("tbl%0d_illegal", i), bus.out_illegal, vecs[i].ill);
        end
        @(posedge clk);
        #1 chk("tbl_drained", bus.out_valid, 0);

        // Back-to-back stream of 8 with out_ready 1,0,0,1,...; an op is held until accepted
        begin
            int n;
            n = 0;
            acc_flag = 1'b1;
            for (int i = 0; i < 40 && n < 8; i++) begin
                if (acc_flag) rand_op();
                step(1'b1, (i % 4 == 0) || (i % 4 == 3));
                if (acc_flag) n++;
            end
            chk("stream_count", n, 8);
        end
        drain();

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            rand_op();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with both stages full and the consumer stalled
        rand_op();
        step(1'b1, 1'b0);
        rand_op();
        step(1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_acl", bus.alu_acl, 0);
        chk("midrst_alu_a", bus.alu_a, 0);
        chk("midrst_result", bus.out_result, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk("post_rst_quiet", bus.out_valid, 0);
        end
        rand_op();
        step(1'b1, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Pipelined issue/capture front end for the 4-bit-encoded ALU: accepts decoded RV32 integer instruction fields plus operand values over a valid/ready handshake, encodes them into the ALU control code and operands, and registers the ALU's result and zero flag back out. It sits between the decode/register-read stage and writeback/branch resolution. It is the encoder-and-driver side of the ALU control interface.

## Interface
- No parameters. Data width is fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  unit can accept this cycle
- in_opcode  in  7  instr[6:0]
- in_funct3  in  3  instr[14:12]
- in_funct7_5  in  1  instr[30]
- in_rs1  in  32  rs1 value
- in_rs2  in  32  rs2 value
- in_imm  in  32  sign-extended I-immediate
- alu_a, alu_b  out  32  registered ALU operands
- alu_acl  out  4  registered ALU control code
- alu_result  in  32  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  captured result
- out_zero  out  1  captured zero flag
- out_taken  out  1  branch taken (branches only)
- out_illegal  out  1  unsupported encoding

## Operation
- Opcodes:
  - R = 0110011: b = rs2.
  - I = 0010011: b = imm.
  - BR = 1100011: b = rs2.
  - Any other opcode is illegal.
- acl encoding by funct3 for R/I:
  - 000: add 0000. R with funct7_5 = 1 gives sub 0001.
  - 001: sll 0010.
  - 010: slt 0011.
  - 100: xor 0100.
  - 101: srl 0101.
  - 110: or 0110.
  - 111: and 0111.
- Illegal R/I encodings:
  - funct3 011.
  - funct7_5 = 1 with any R funct3 other than 000 or 101.
  - funct3 101 with funct7_5 = 1 (sra/srai are unsupported).
  - I-type shifts with imm[11:5] ≠ 0.
- Shifts: b is zero-extended from its low 5 bits (rs2[4:0] or imm[4:0]).
- Branches: acl = 0001 (a − b).
  - funct3 000 (BEQ): out_taken = zero.
  - funct3 001 (BNE): out_taken = !zero.
  - Any other branch funct3 is illegal.
  - Non-branch instructions have out_taken = 0.
- Illegal entries still flow through the pipeline in order, with a = b = 0 and acl = 0000. At the output they show out_illegal = 1, out_result = 0, out_zero = 0 and out_taken = 0.
- Stage S1 (issue register) holds s1_valid, alu_a, alu_b, alu_acl, branch/illegal tags and funct3[0].
- Stage S2 (capture register) holds out_* and out_valid.
- advance = !out_valid || out_ready.
- in_ready = !s1_valid || advance. This is combinational and has no dependency on in_valid.
- When advance = 1, S2 loads from S1: out_valid ← s1_valid, result/zero/taken from alu_* and the tags.
- On an accept (in_valid && in_ready), S1 loads the new fields. Otherwise, if advance = 1, s1_valid ← 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - All registers clear: s1_valid = 0, out_valid = 0.
  - alu_a = alu_b = 0, alu_acl = 0000.
  - out_result = 0, out_zero = out_taken = out_illegal = 0.
  - in_ready = 1 once reset is released.
- Latency: an instruction accepted at edge N appears with out_valid = 1 after edge N+1. The ALU is evaluated between N and N+1.
- Throughput: one instruction per cycle while out_ready = 1.
- Output stability: while out_valid && !out_ready, out_* and S1 hold, and in_ready = 0 if S1 is occupied.
- Simultaneous accept and drain in the same cycle is legal: S1 is replaced and S2 is replaced. No bubble, no loss, no duplication.
- Reset mid-operation discards both stages. No output follows reset without a new accept.
- Input fields are sampled only on an accept. They are don't-care otherwise.

## Test plan
- ADD rs1 = 5, rs2 = 7 → alu_acl = 0000, out_result = 12, out_zero = 0, out_valid two edges after accept.
- SUB (funct7_5 = 1) rs1 = rs2 = 0x1234 → acl 0001, out_result = 0, out_zero = 1. BEQ with the same operands → out_taken = 1; BNE → out_taken = 0.
- SLLI imm = 0x004, rs1 = 1 → alu_b = 4, out_result = 16. SLL with rs2 = 0x23 → b = 3, result 8. SRAI (funct7_5 = 1) → out_illegal = 1, out_result = 0.
- Back-to-back stream of 8 ops with out_ready toggled 1,0,0,1,…:
  - Results emerge in order, none dropped or duplicated.
  - out_* stable while stalled; in_ready drops only when both stages are full.
- Illegal cases: funct3 011, opcode 0000011, branch funct3 100 → out_illegal = 1, out_taken = 0, ordering with neighbouring legal ops preserved.
- Assert rst_n low with both stages full → out_valid = 0 and acl = 0000 immediately, with no output after release until a new accept.
